alu_shifter_seq: RTL and testbench

Parametrised, multi-cycle successor to the ALU input shifter. It executes Z80-style rotate/shift operations (op543 encoding) on a WIDTH-bit operand. The shift amount is programmable, and the block performs one bit per clock. It sits beside the ALU core, takes an operand and carry from the datapath, and returns the result, carry-out and S/Z/P flags with a start/busy/done handshake.

---
 rtl/alu_shifter_seq.sv | 124 ++++++++++++
 tb/tb_alu_shifter_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_shifter_seq.sv
// Multi-cycle Z80-style rotate/shift unit: one bit per clock, programmable step count,
// start/busy/done handshake with registered result, carry and S/Z/P flags.
module alu_shifter_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op543,
    input  logic [WIDTH-1:0] din,
    input  logic             cf_in,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cf_out,
    output logic             sf,
    output logic             zf,
    output logic             pf
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SLL, OP_SRL} op_t;

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    op_t              op_r;
    logic [WIDTH-1:0] work_r;
    logic             carry_r;
    logic [CNT_W-1:0] remaining;

    logic [CNT_W-1:0] count_clamped;
    logic [WIDTH-1:0] step_r;
    logic             step_c;
    logic [WIDTH-1:0] fin_r;
    logic             fin_c;
    logic             load_out;

    assign count_clamped = (count > WIDTH_CNT) ? WIDTH_CNT : count;

    // One single-bit step of the latched operation on the working register and carry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        step_r = work_r;
        step_c = carry_r;
        case (op_r)
            OP_RLC: begin step_c = work_r[WIDTH-1]; step_r = {work_r[WIDTH-2:0], work_r[WIDTH-1]}; end
            OP_RRC: begin step_c = work_r[0];       step_r = {work_r[0], work_r[WIDTH-1:1]};       end
            OP_RL:  begin step_c = work_r[WIDTH-1]; step_r = {work_r[WIDTH-2:0], carry_r};         end
            OP_RR:  begin step_c = work_r[0];       step_r = {carry_r, work_r[WIDTH-1:1]};         end
            OP_SLA: begin step_c = work_r[WIDTH-1]; step_r = {work_r[WIDTH-2:0], 1'b0};            end
            OP_SRA: begin step_c = work_r[0];       step_r = {work_r[WIDTH-1], work_r[WIDTH-1:1]}; end
            OP_SLL: begin step_c = work_r[WIDTH-1]; step_r = {work_r[WIDTH-2:0], 1'b1};            end
            OP_SRL: begin step_c = work_r[0];       step_r = {1'b0, work_r[WIDTH-1:1]};            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (count_clamped == '0) ? DONE : SHIFT;
            SHIFT:   if (remaining == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // A zero-count start goes straight to DONE, so the result comes from the inputs themselves.
    assign load_out = (state_nxt == DONE) && (state != DONE);
    assign fin_r    = (state == IDLE) ? din   : step_r;
    assign fin_c    = (state == IDLE) ? cf_in : step_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r      <= OP_RLC;
            work_r    <= '0;
            carry_r   <= 1'b0;
            remaining <= '0;
            dout      <= '0;
            cf_out    <= 1'b0;
            sf        <= 1'b0;
            zf        <= 1'b0;
            pf        <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_r      <= op_t'(op543);
                work_r    <= din;
                carry_r   <= cf_in;
                remaining <= count_clamped;
            end else if (state == SHIFT) begin
                work_r    <= step_r;
                carry_r   <= step_c;
                remaining <= remaining - CNT_W'(1);
            end

            // Results and flags only move on entry to DONE; they hold through later SHIFTs.
            if (load_out) begin
                dout   <= fin_r;
                cf_out <= fin_c;
                sf     <= fin_r[WIDTH-1];
                zf     <= (fin_r == '0);
                pf     <= ~^fin_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_shifter_seq.sv
// Self-checking bench for alu_shifter_seq: closed-form behavioural model with a per-cycle
// compare process, plus directed vectors carrying hand-computed results.
module tb_alu_shifter_seq;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op543;
    logic [N-1:0]  din;
    logic          cf_in;
    logic [CW-1:0] count;
    logic          busy, done;
    logic [N-1:0]  dout;
    logic          cf_out, sf, zf, pf;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_shifter_seq #(.WIDTH(N), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op543  (op543),
        .din    (din),
        .cf_in  (cf_in),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .cf_out (cf_out),
        .sf     (sf),
        .zf     (zf),
        .pf     (pf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Closed-form result of n steps: rotates as whole-word/ring rotations, shifts as arithmetic.
    function automatic logic [N:0] model(input logic [2:0] op, input logic [N-1:0] d,
                                         input logic c, input int n_in);
        longint r, ring, mask, rmask, full, s;
        int     n;
        logic   co;
        n     = (n_in > N) ? N : n_in;
        mask  = (longint'(1) << N) - 1;
        rmask = (mask << 1) | 1;
        r     = longint'(d);
        co    = c;
        if (n == 0) return {c, d};
        case (op)
            3'd0: begin r = ((r << n) | (r >> (N - n))) & mask; co = r[0]; end
            3'd1: begin r = ((r >> n) | (r << (N - n))) & mask; co = r[N-1]; end
            3'd2: begin
                ring = (longint'(c) << N) | r;
                ring = ((ring << n) | (ring >> (N + 1 - n))) & rmask;
                co = ring[N]; r = ring & mask;
            end
            3'd3: begin
                ring = (longint'(c) << N) | r;
                ring = ((ring >> n) | (ring << (N + 1 - n))) & rmask;
                co = ring[N]; r = ring & mask;
            end
            3'd4: begin full = r << n; co = full[N]; r = full & mask; end
            3'd5: begin
                co = r[n-1];
                s  = r[N-1] ? (r - (mask + 1)) : r;
                r  = (s >>> n) & mask;
            end
            3'd6: begin full = (r << n) | ((longint'(1) << n) - 1); co = full[N]; r = full & mask; end
            default: begin co = r[n-1]; r = r >> n; end
        endcase
        return {co, r[N-1:0]};
    endfunction

    // Transaction-level expectation: edges left until DONE, and the result it will show.
    int           m_left = -1;
    logic         m_done = 1'b0;
    logic [N:0]   m_pend = '0;
    logic [N-1:0] e_dout = '0;
    logic         e_cf = 1'b0, e_sf = 1'b0, e_zf = 1'b0, e_pf = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= -1; m_done <= 1'b0;
            e_dout <= '0; e_cf <= 1'b0; e_sf <= 1'b0; e_zf <= 1'b0; e_pf <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_left <= -1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                e_dout <= m_pend[N-1:0]; e_cf <= m_pend[N];
                e_sf   <= m_pend[N-1]; e_zf <= (m_pend[N-1:0] == 0);
                e_pf   <= ($countones(m_pend[N-1:0]) % 2 == 0);
            end
        end else if (start) begin
            m_pend <= model(op543, din, cf_in, int'(count));
            m_left <= (int'(count) > N) ? N : int'(count);
            if (count == 0) begin
                m_done <= 1'b1;
                e_dout <= din; e_cf <= cf_in;
                e_sf   <= din[N-1]; e_zf <= (din == 0);
                e_pf   <= ($countones(din) % 2 == 0);
            end
        end
    end

    always @(negedge clk) begin
        check("busy",   busy,   m_left >= 0);
        check("done",   done,   m_done);
        check("dout",   dout,   e_dout);
        check("cf_out", cf_out, e_cf);
        check("sf",     sf,     e_sf);
        check("zf",     zf,     e_zf);
        check("pf",     pf,     e_pf);
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [N-1:0] d,
                          input logic c, input logic [CW-1:0] cnt, input logic [N-1:0] x_dout,
                          input logic x_cf, input logic x_sf, input logic x_zf, input logic x_pf,
                          input int x_cyc);
        int cyc = 0;
        @(posedge clk); #2;
        op543 = op; din = d; cf_in = c; count = cnt; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; op543 = ~op; din = ~d; cf_in = ~c; count = '0;
        for (int k = 1; k <= 40 && cyc == 0; k++) begin
            @(negedge clk);
            if (done) cyc = k;
        end
        check({name, " latency"}, cyc, x_cyc);
        check({name, " dout"}, dout, x_dout);
        check({name, " cf"}, cf_out, x_cf);
        check({name, " flags"}, {sf, zf, pf}, {x_sf, x_zf, x_pf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; op543 = '0; din = '0; cf_in = 1'b0; count = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset state", {busy, done, dout, cf_out, sf, zf, pf}, '0);
        reset = 1'b0;

        //     name         op    din    cf cnt    dout   cf sf zf pf cyc
        run_op("rlc81",     3'd0, 8'h81, 0, 4'd1,  8'h03, 1, 0, 0, 1, 2);
        run_op("rr01",      3'd3, 8'h01, 0, 4'd2,  8'h80, 0, 1, 0, 0, 3);
        run_op("sra80",     3'd5, 8'h80, 0, 4'd3,  8'hF0, 0, 1, 0, 1, 4);
        run_op("sll_cnt0",  3'd6, 8'h55, 1, 4'd0,  8'h55, 1, 0, 0, 1, 1);
        run_op("rlc_clamp", 3'd0, 8'hA5, 0, 4'd15, 8'hA5, 1, 1, 0, 1, 9);
        run_op("rrc01",     3'd1, 8'h01, 0, 4'd1,  8'h80, 1, 1, 0, 0, 2);
        run_op("sla81",     3'd4, 8'h81, 0, 4'd2,  8'h04, 0, 0, 0, 0, 3);
        run_op("rl80",      3'd2, 8'h80, 1, 4'd1,  8'h01, 1, 0, 0, 0, 2);
        run_op("rr_full",   3'd3, 8'h01, 1, 4'd8,  8'h03, 0, 0, 0, 1, 9);
        run_op("rl_full",   3'd2, 8'h01, 0, 4'd8,  8'h00, 1, 0, 1, 1, 9);
        run_op("rrc_full",  3'd1, 8'hB4, 0, 4'd8,  8'hB4, 1, 1, 0, 1, 9);
        run_op("srl_clamp", 3'd7, 8'hFF, 0, 4'd9,  8'h00, 1, 0, 1, 1, 9);

        // SRL to zero while start is held through SHIFT and DONE with a different operand.
        @(posedge clk); #2;
        op543 = 3'd7; din = 8'h01; cf_in = 1'b0; count = 4'd1; start = 1'b1;
        @(posedge clk); #2;
        op543 = 3'd0; din = 8'hFF; count = 4'd3;
        @(posedge clk); #2;
        check("srl done", done, 1'b1);
        check("srl result", {dout, cf_out, sf, zf, pf}, {8'h00, 1'b1, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy start ignored", busy, 1'b0);
        check("srl held", {dout, cf_out, zf}, {8'h00, 1'b1, 1'b1});

        // Reset after two shifts of an RL: outputs clear at once and no done appears.
        @(posedge clk); #2;
        op543 = 3'd2; din = 8'h12; cf_in = 1'b0; count = 4'd5; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("rl busy before abort", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("abort clears", {busy, done, dout, cf_out, sf, zf, pf}, '0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no done after abort", seen, 0);
        run_op("rlc_after_reset", 3'd0, 8'h81, 0, 4'd1, 8'h03, 1, 0, 0, 1, 2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
